// File: rtl/decode_imm_ctrl.sv
// decode_imm_ctrl: 2-entry in-order decode buffer (head + skid) that
// extends each instruction's immediate when the word is accepted.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   if_valid/if_ready          upstream handshake (if_ready is registered)
//   if_inst, if_pc             fetched word and its PC
//   flush                      drop buffered and incoming words
//   id_valid/id_ready          downstream handshake
//   id_inst, id_pc             head entry instruction and PC
//   id_imm, id_imm_op          head entry extended immediate and ext_op code
//   id_buf_cnt                 occupied entries (0..2)
// Optional build macro: DECODE_BR_OFFS_EN adds branch-offset ext_op codes.
// ext_op codes normally come from the shared defines.vh; the guarded
// fallbacks below hold the same values when it is not included first.

`ifndef EXT_DEFAULT
`define EXT_DEFAULT 3'd0
`endif
`ifndef EXT_20
`define EXT_20 3'd1
`endif
`ifndef EXT_12_SEXT
`define EXT_12_SEXT 3'd2
`endif
`ifndef EXT_12_ZEXT
`define EXT_12_ZEXT 3'd3
`endif
`ifndef EXT_16_BR
`define EXT_16_BR 3'd4
`endif
`ifndef EXT_26_BR
`define EXT_26_BR 3'd5
`endif

module decode_imm_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_valid,
   output logic        if_ready,
   input  logic [31:0] if_inst,
   input  logic [31:0] if_pc,
   input  logic        flush,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_imm,
   output logic [2:0]  id_imm_op,
   output logic [1:0]  id_buf_cnt
);

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  op;
   } entry_t;

   localparam entry_t ENTRY_RST = '{
      inst: 32'h0,
      pc:   32'h0,
      imm:  32'h0,
      op:   `EXT_DEFAULT
   };

   entry_t head_q;
   entry_t head_d;
   entry_t skid_q;
   entry_t skid_d;
   entry_t new_e;

   logic head_vq;
   logic head_vd;
   logic skid_vq;
   logic skid_vd;
   logic rdy_q;
   logic rdy_d;

   logic accept;
   logic drain;

   logic [9:0] op10;
   logic       is_lu12i;
   logic       is_sext;
   logic       is_zext;
`ifdef DECODE_BR_OFFS_EN
   logic [5:0] op6;
   logic       is_b16;
   logic       is_b26;
`endif

   // ---------------- immediate decode at accept time
   assign op10     = if_inst[31:22];
   assign is_lu12i = (if_inst[31:25] == 7'b0001010);
   assign is_sext  = (op10 == 10'b0000001010) ||
                     (op10 == 10'b0010100010) ||
                     (op10 == 10'b0010100110) ||
                     (op10 == 10'b0000001000);
   assign is_zext  = (op10 == 10'b0000001101) ||
                     (op10 == 10'b0000001110) ||
                     (op10 == 10'b0000001111);
`ifdef DECODE_BR_OFFS_EN
   assign op6    = if_inst[31:26];
   assign is_b16 = (op6 >= 6'b010110) && (op6 <= 6'b011011);
   assign is_b26 = (op6[5:1] == 5'b01010);
`endif

   always_comb begin
      new_e.inst = if_inst;
      new_e.pc   = if_pc;
      new_e.op   = `EXT_DEFAULT;
      new_e.imm  = {6'h0, if_inst[25:0]};
      unique case (1'b1)
         is_lu12i: begin
            new_e.op  = `EXT_20;
            new_e.imm = {if_inst[24:5], 12'h000};
         end
         is_sext: begin
            new_e.op  = `EXT_12_SEXT;
            new_e.imm = {{20{if_inst[21]}}, if_inst[21:10]};
         end
         is_zext: begin
            new_e.op  = `EXT_12_ZEXT;
            new_e.imm = {20'h0, if_inst[21:10]};
         end
`ifdef DECODE_BR_OFFS_EN
         is_b16: begin
            new_e.op  = `EXT_16_BR;
            new_e.imm = {{14{if_inst[25]}}, if_inst[25:10], 2'b00};
         end
         is_b26: begin
            new_e.op  = `EXT_26_BR;
            new_e.imm = {{4{if_inst[9]}}, if_inst[9:0],
                         if_inst[25:10], 2'b00};
         end
`endif
         default: ;
      endcase
   end

   // ---------------- buffer next state
   // if_ready is low whenever the skid is full, so a drain that pulls
   // the skid into the head never coincides with an accept.
   assign accept = if_valid & rdy_q;
   assign drain  = head_vq & id_ready;

   always_comb begin
      head_d  = head_q;
      head_vd = head_vq;
      skid_d  = skid_q;
      skid_vd = skid_vq;
      if (flush) begin
         head_d  = ENTRY_RST;
         head_vd = 1'b0;
         skid_d  = ENTRY_RST;
         skid_vd = 1'b0;
      end else if (drain) begin
         if (skid_vq) begin
            head_d  = skid_q;
            skid_vd = 1'b0;
         end else if (accept) begin
            head_d = new_e;
         end else begin
            head_vd = 1'b0;
         end
      end else if (accept) begin
         if (head_vq) begin
            skid_d  = new_e;
            skid_vd = 1'b1;
         end else begin
            head_d  = new_e;
            head_vd = 1'b1;
         end
      end
      rdy_d = ~skid_vd;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= ENTRY_RST;
         head_vq <= 1'b0;
         skid_q  <= ENTRY_RST;
         skid_vq <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         head_q  <= head_d;
         head_vq <= head_vd;
         skid_q  <= skid_d;
         skid_vq <= skid_vd;
         rdy_q   <= rdy_d;
      end
   end

   // ---------------- outputs
   assign if_ready   = rdy_q;
   assign id_valid   = head_vq;
   assign id_inst    = head_q.inst;
   assign id_pc      = head_q.pc;
   assign id_imm     = head_q.imm;
   assign id_imm_op  = head_q.op;
   assign id_buf_cnt = {1'b0, head_vq} + {1'b0, skid_vq};

endmodule
